// File: rtl/rr_arb2_pkt.sv
// Two-requester round-robin packet arbiter feeding one registered output stage.
// A grant stays on one requester from the first accepted beat until its last beat.
module rr_arb2_pkt #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    input  logic             in0_last,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    input  logic             in1_last,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_src,
    input  logic             out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_prio;
    logic             w_prio_nxt;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_last;
    logic             r_out_src;

    logic             w_load_en;
    logic             w_g0;
    logic             w_g1;
    logic             w_acc0;
    logic             w_acc1;
    logic             w_acc;
    logic             w_acc_last;
    logic [WIDTH-1:0] w_sel_data;

    // Output stage can take a new beat when empty or draining this cycle.
    assign w_load_en = !r_out_valid | out_ready;

    // One-hot grant: locked state wins, otherwise round-robin on contention.
    always_comb begin
        w_g0 = 1'b0;
        w_g1 = 1'b0;
        case (r_state)
            IDLE: begin
                if (in0_valid && in1_valid) begin
                    w_g0 = !r_prio;
                    w_g1 = r_prio;
                end else begin
                    w_g0 = in0_valid;
                    w_g1 = in1_valid;
                end
            end
            LOCK0:   w_g0 = 1'b1;
            LOCK1:   w_g1 = 1'b1;
            default: begin
                w_g0 = 1'b0;
                w_g1 = 1'b0;
            end
        endcase
    end

    assign in0_ready  = w_load_en & w_g0;
    assign in1_ready  = w_load_en & w_g1;
    assign w_acc0     = in0_valid & in0_ready;
    assign w_acc1     = in1_valid & in1_ready;
    assign w_acc      = w_acc0 | w_acc1;
    assign w_acc_last = w_acc0 ? in0_last : in1_last;

    // AND-OR data select; grants are one-hot so at most one term is live.
    assign w_sel_data = (in0_data & {WIDTH{w_g0}}) | (in1_data & {WIDTH{w_g1}});

    // Next-state and priority update; priority moves only on a packet's last beat.
    always_comb begin
        w_state_nxt = r_state;
        w_prio_nxt  = r_prio;
        case (r_state)
            IDLE: begin
                if (w_acc && !w_acc_last) begin
                    w_state_nxt = w_acc1 ? LOCK1 : LOCK0;
                end
            end
            LOCK0: begin
                if (w_acc0 && in0_last) begin
                    w_state_nxt = IDLE;
                end
            end
            LOCK1: begin
                if (w_acc1 && in1_last) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        if (w_acc && w_acc_last) begin
            w_prio_nxt = w_acc0;
        end
    end

    // State and priority registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_prio  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_prio  <= w_prio_nxt;
        end
    end

    // Output register: load on accept, empty on an idle drain, hold when stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
            r_out_src   <= 1'b0;
        end else if (w_load_en) begin
            if (w_acc) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_last  <= w_acc_last;
                r_out_src   <= w_acc1;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign out_src   = r_out_src;

endmodule

// File: tb/tb_rr_arb2_pkt.sv
// Directed bench for rr_arb2_pkt: inputs change on the falling edge,
// ready is checked just after, registered outputs one falling edge later.
module tb_rr_arb2_pkt;

    localparam int unsigned WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_last;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_last;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_src;
    logic             out_ready;

    int checks = 0;
    int errors = 0;

    rr_arb2_pkt #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_last  (in0_last),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_last  (in1_last),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
        in0_data = 8'h00; in1_data = 8'h00; in0_last = 1'b0; in1_last = 1'b0;
        step(); step();
        rst = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %0b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_out_data got %h want 00", out_data); end
        checks++; if ({out_last, out_src} !== 2'b00) begin errors++; $display("FAIL rst_last_src got %b want 00", {out_last, out_src}); end
        checks++; if ({in0_ready, in1_ready} !== 2'b00) begin errors++; $display("FAIL rst_idle_ready got %b want 00", {in0_ready, in1_ready}); end
        in0_valid = 1'b1; #1;
        checks++; if ({in0_ready, in1_ready} !== 2'b10) begin errors++; $display("FAIL rst_ready0 got %b want 10", {in0_ready, in1_ready}); end
        in0_valid = 1'b0; in1_valid = 1'b1; #1;
        checks++; if ({in0_ready, in1_ready} !== 2'b01) begin errors++; $display("FAIL rst_ready1 got %b want 01", {in0_ready, in1_ready}); end
        in1_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_idle_valid got %0b want 0", out_valid); end
    endtask

    task automatic test_contention();
        logic [7:0] exp_d;
        in0_valid = 1'b1; in0_data = 8'hA5; in0_last = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h3C; in1_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if ({in0_ready, in1_ready} !== ((k % 2 == 0) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL cont_ready[%0d] got %b", k, {in0_ready, in1_ready}); end
            step();
            exp_d = (k % 2 == 0) ? 8'hA5 : 8'h3C;
            checks++; if (out_data !== exp_d || out_src !== 1'(k % 2) || out_valid !== 1'b1) begin errors++; $display("FAIL cont_out[%0d] got %h src %0b want %h src %0d", k, out_data, out_src, exp_d, k % 2); end
        end
        in0_valid = 1'b0; in1_valid = 1'b0;
        step();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL cont_drain got %0b want 0", out_valid); end
    endtask

    task automatic test_lock();
        logic [7:0] beats [3];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
        in1_valid = 1'b1; in1_data = 8'h77; in1_last = 1'b1;
        in0_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in0_data = beats[k]; in0_last = (k == 2); #1;
            checks++; if ({in0_ready, in1_ready} !== 2'b10) begin errors++; $display("FAIL lock_ready[%0d] got %b want 10", k, {in0_ready, in1_ready}); end
            step();
            checks++; if (out_data !== beats[k] || out_src !== 1'b0 || out_last !== (k == 2)) begin errors++; $display("FAIL lock_out[%0d] got %h last %0b want %h", k, out_data, out_last, beats[k]); end
        end
        // in0 still requesting, but priority has moved to in1
        in0_data = 8'h44; in0_last = 1'b1; #1;
        checks++; if ({in0_ready, in1_ready} !== 2'b01) begin errors++; $display("FAIL lock_prio got %b want 01", {in0_ready, in1_ready}); end
        step();
        checks++; if (out_data !== 8'h77 || out_src !== 1'b1) begin errors++; $display("FAIL lock_next got %h src %0b want 77 src 1", out_data, out_src); end
        in0_valid = 1'b0; in1_valid = 1'b0;
        step();
    endtask

    task automatic test_backpressure();
        in0_valid = 1'b1; in0_data = 8'h5A; in0_last = 1'b0;
        in1_valid = 1'b1; in1_data = 8'h66; in1_last = 1'b1;
        out_ready = 1'b1;
        step();
        checks++; if (out_data !== 8'h5A || out_valid !== 1'b1) begin errors++; $display("FAIL bp_first got %h v %0b want 5A v 1", out_data, out_valid); end
        out_ready = 1'b0; in0_data = 8'h6B; in0_last = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if ({in0_ready, in1_ready} !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d] got %b want 00", k, {in0_ready, in1_ready}); end
            step();
            checks++; if (out_data !== 8'h5A || out_valid !== 1'b1 || out_last !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d] got %h v %0b", k, out_data, out_valid); end
        end
        out_ready = 1'b1; #1;
        checks++; if ({in0_ready, in1_ready} !== 2'b10) begin errors++; $display("FAIL bp_lock_kept got %b want 10", {in0_ready, in1_ready}); end
        step();
        checks++; if (out_data !== 8'h6B || out_last !== 1'b1 || out_src !== 1'b0) begin errors++; $display("FAIL bp_resume got %h last %0b want 6B last 1", out_data, out_last); end
        in0_valid = 1'b0; #1;
        checks++; if ({in0_ready, in1_ready} !== 2'b01) begin errors++; $display("FAIL bp_in1_ready got %b want 01", {in0_ready, in1_ready}); end
        step();
        checks++; if (out_data !== 8'h66 || out_src !== 1'b1) begin errors++; $display("FAIL bp_in1_out got %h want 66", out_data); end
        in1_valid = 1'b0;
        step();
    endtask

    task automatic test_bubble();
        in1_valid = 1'b1; in1_data = 8'h99; in1_last = 1'b1;
        in0_valid = 1'b1; in0_data = 8'h01; in0_last = 1'b0;
        #1;
        checks++; if ({in0_ready, in1_ready} !== 2'b10) begin errors++; $display("FAIL bub_first_ready got %b want 10", {in0_ready, in1_ready}); end
        step();
        checks++; if (out_data !== 8'h01 || out_last !== 1'b0) begin errors++; $display("FAIL bub_first got %h last %0b want 01 last 0", out_data, out_last); end
        in0_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if ({in0_ready, in1_ready} !== 2'b10) begin errors++; $display("FAIL bub_gap_ready[%0d] got %b want 10", k, {in0_ready, in1_ready}); end
            step();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bub_gap_valid[%0d] got %0b want 0", k, out_valid); end
        end
        in0_valid = 1'b1; in0_data = 8'h02; in0_last = 1'b1;
        step();
        checks++; if (out_data !== 8'h02 || out_last !== 1'b1 || out_src !== 1'b0) begin errors++; $display("FAIL bub_last got %h last %0b want 02 last 1", out_data, out_last); end
        in0_valid = 1'b0; #1;
        checks++; if (in1_ready !== 1'b1) begin errors++; $display("FAIL bub_release got %0b want 1", in1_ready); end
        step();
        checks++; if (out_data !== 8'h99 || out_src !== 1'b1) begin errors++; $display("FAIL bub_in1 got %h want 99", out_data); end
        in1_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        in1_valid = 1'b1; in1_data = 8'hC1; in1_last = 1'b0;
        step();
        checks++; if (out_data !== 8'hC1 || out_src !== 1'b1 || out_valid !== 1'b1) begin errors++; $display("FAIL rm_first got %h src %0b", out_data, out_src); end
        rst = 1'b1; #1;
        checks++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_src !== 1'b0) begin errors++; $display("FAIL rm_async got v %0b d %h src %0b want 0 00 0", out_valid, out_data, out_src); end
        step();
        rst = 1'b0;
        in1_data = 8'hC2; in1_last = 1'b1;
        in0_valid = 1'b1; in0_data = 8'hD0; in0_last = 1'b1; #1;
        checks++; if ({in0_ready, in1_ready} !== 2'b10) begin errors++; $display("FAIL rm_idle_prio got %b want 10", {in0_ready, in1_ready}); end
        step();
        checks++; if (out_data !== 8'hD0 || out_src !== 1'b0) begin errors++; $display("FAIL rm_winner got %h src %0b want D0 src 0", out_data, out_src); end
        in0_valid = 1'b0; in1_valid = 1'b0;
        step();
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_contention();
        test_lock();
        test_backpressure();
        test_bubble();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
